// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int                   DIV_CNT_W     = cnt_width(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvsr,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_borrow;

    assign w_shift  = {i_rem, i_quo[WIDTH-1]};
    // The running remainder is always below the divisor, so the shifted value
    // fits in WIDTH+1 bits and the top bit of the difference is a clean borrow.
    assign w_trial  = w_shift - {2'b00, i_dvsr};
    assign w_borrow = w_trial[WIDTH+1];

    assign o_rem = w_borrow ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/divider.sv
// Iterative restoring divider with MIPS-style start/fim handshake (quotient on lo, remainder on hi).
// Signed division (div) is built only when DIVIDER_SIGNED_EN is defined; otherwise always divu.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             signed_op,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fim,
    output logic             busy,
    output logic             divzero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_fim;
    logic             r_divzero;

    logic             w_div0;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_quo_out;
    logic [WIDTH-1:0] w_rem_out;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_div0 = (r_op2 == '0);

`ifdef DIVIDER_SIGNED_EN
    logic r_signed;
    logic r_neg_q;
    logic r_neg_r;
    logic w_neg1;
    logic w_neg2;

    assign w_neg1    = r_signed & r_op1[WIDTH-1];
    assign w_neg2    = r_signed & r_op2[WIDTH-1];
    assign w_mag1    = w_neg1 ? -r_op1 : r_op1;
    assign w_mag2    = w_neg2 ? -r_op2 : r_op2;
    // Truncation toward zero: quotient negated on sign mismatch, remainder follows the dividend.
    assign w_quo_out = r_neg_q ? -r_quo : r_quo;
    assign w_rem_out = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_signed <= signed_op;
        end else if (r_state == PREP) begin
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
        end
    end
`else
    logic w_unused_signed_op;

    assign w_unused_signed_op = signed_op;
    assign w_mag1             = r_op1;
    assign w_mag2             = r_op2;
    assign w_quo_out          = r_quo;
    assign w_rem_out          = r_rem[WIDTH-1:0];
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvsr (r_dvsr),
        .o_rem  (w_rem_nxt),
        .o_quo  (w_quo_nxt)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = PREP;
            PREP:    w_next = w_div0 ? DONE : CALC;
            CALC:    if (r_cnt == CW'(1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b1;
        if (r_state == IDLE) busy = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_dvsr    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_fim     <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_fim <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op1 <= operand1;
                        r_op2 <= operand2;
                    end
                end
                PREP: begin
                    if (w_div0) begin
                        r_hi      <= r_op1;
                        r_lo      <= {WIDTH{DIV0_QUOTIENT[0]}};
                        r_divzero <= 1'b1;
                        r_fim     <= 1'b1;
                    end else begin
                        r_rem     <= '0;
                        r_quo     <= w_mag1;
                        r_dvsr    <= w_mag2;
                        r_cnt     <= CW'(WIDTH);
                        r_divzero <= 1'b0;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CW'(1);
                end
                FIX: begin
                    r_lo  <= w_quo_out;
                    r_hi  <= w_rem_out;
                    r_fim <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign fim     = r_fim;
    assign divzero = r_divzero;

endmodule
